// File: rtl/axi_slave_bus.sv
// AXI4-Lite slave exposing four 32-bit read/write control registers
// at byte offsets 0x0/0x4/0x8/0xC (word index = addr[3:2]).
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN       clock, async active-low reset
//   S_AXI_AW*/S_AXI_W*              write address / data (AW and W
//                                   must be presented together)
//   S_AXI_B*                        write response
//   S_AXI_AR*                       read address
//   S_AXI_R*                        read data / response
//
// Optional feature macro: AXI_SLVERR_EN
//   defined   -> out-of-range accesses answer SLVERR (2'b10)
//   undefined -> out-of-range accesses answer OKAY (2'b00)
// In both builds out-of-range writes are dropped and reads return 0.
module axi_slave_bus #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int NB = DW / 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    logic [DW-1:0] regs [4];

    // AWREADY and WREADY are one shared register: AW and W are
    // always accepted on the same edge.
    logic          wr_ready;
    logic          bvalid;
    logic [1:0]    bresp;

    logic          ar_ready;
    logic [1:0]    ar_idx;
    logic          ar_oor;
    logic          rvalid;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;

    logic [1:0]    w_idx;
    logic          w_oor;
    logic          wr_accept;
    logic          wr_fire;
    logic          ar_accept;

    assign w_idx     = S_AXI_AWADDR[3:2];
    assign w_oor     = |S_AXI_AWADDR[AW-1:4];
    assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID
                       && !wr_ready && !bvalid;
    assign wr_fire   = wr_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign ar_accept = S_AXI_ARVALID && !ar_ready && !rvalid;

    // Register file: written only on the AW/W handshake edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire && !w_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    regs[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Write address/data acceptance and response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ready <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_ready <= wr_accept;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= w_oor ? RESP_OOR : RESP_OKAY;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read: address latched on the accept edge, data sampled from
    // the pre-edge register contents one edge later.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_ready <= 1'b0;
            ar_idx   <= 2'b00;
            ar_oor   <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            ar_ready <= ar_accept;
            if (ar_accept) begin
                ar_idx <= S_AXI_ARADDR[3:2];
                ar_oor <= |S_AXI_ARADDR[AW-1:4];
            end
            if (ar_ready) begin
                rvalid <= 1'b1;
                rdata  <= ar_oor ? '0 : regs[ar_idx];
                rresp  <= ar_oor ? RESP_OOR : RESP_OKAY;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = wr_ready;
    assign S_AXI_WREADY  = wr_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    // Protection bits and byte offset within a word carry no meaning.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_slave_bus.sv
// Randomized self-checking bench for axi_slave_bus against a
// register-array model with expected-response queues.
module tb_axi_slave_bus;

    localparam int AW = 8;

`ifdef AXI_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;

    always #5 clk = ~clk;

    axi_slave_bus #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [4];
    logic [1:0]  bq [$];
    logic [31:0] rdq [$];
    logic [1:0]  rrq [$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout or unexpected event", name);
    endtask

    function automatic logic oor(input logic [AW-1:0] a);
        return |a[AW-1:4];
    endfunction

    // Compare process: every handshake cycle on B and R is checked
    // against the queued expectation; reset values while in reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl",
                  {25'b0, awready, wready, bvalid, bresp,
                   arready, rvalid},
                  32'h0);
            check("rst_resp", {30'b0, rresp}, 32'h0);
            check("rst_rdata", rdata, 32'h0);
        end else begin
            if (bvalid && bready) begin
                if (bq.size() == 0) fail("bresp_unexpected");
                else check("bresp", {30'b0, bresp},
                           {30'b0, bq.pop_front()});
            end
            if (rvalid && rready) begin
                if (rdq.size() == 0) fail("rdata_unexpected");
                else begin
                    check("rdata", rdata, rdq.pop_front());
                    check("rresp", {30'b0, rresp},
                          {30'b0, rrq.pop_front()});
                end
            end
        end
    end

    task automatic write_present(input logic [AW-1:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] s);
        if (!oor(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mreg[a[3:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        bq.push_back(oor(a) ? OOR : 2'b00);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
    endtask

    task automatic write_accept(output int lat);
        lat = 0;
        while (!awready) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat > 50) begin
                fail("awready_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (!(bvalid && bready)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                fail("bvalid_wait");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic regwrite(input logic [AW-1:0] a,
                            input logic [31:0] d,
                            input logic [3:0] s);
        int lat;
        write_present(a, d, s);
        write_accept(lat);
        wait_b();
    endtask

    task automatic regread(input logic [AW-1:0] a,
                           output logic [31:0] d,
                           output logic [1:0] r);
        int n = 0;
        rdq.push_back(oor(a) ? 32'h0 : mreg[a[3:2]]);
        rrq.push_back(oor(a) ? OOR : 2'b00);
        araddr  = a;
        arvalid = 1'b1;
        d = 32'hx;
        r = 2'bx;
        while (!arready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                fail("arready_wait");
                arvalid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!(rvalid && rready)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                fail("rvalid_wait");
                return;
            end
        end
        d = rdata;
        r = rresp;
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   rd;
    logic [1:0]    rr;
    int            lat;
    logic [31:0]   exp4 [4];

    initial begin
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset contents.
        for (int i = 0; i < 4; i++) begin
            regread(8'(4 * i), rd, rr);
            check("reset_reg", rd, 32'h0);
            check("reset_rresp", {30'b0, rr}, 32'h0);
        end

        // Full write plus latency: ready one edge, BVALID next edge.
        write_present(8'h04, 32'h12345678, 4'hF);
        write_accept(lat);
        check("wr_ready_lat", lat, 1);
        check("bvalid_n2", {31'b0, bvalid}, 32'h1);
        wait_b();
        regread(8'h04, rd, rr);
        check("reg4_full", rd, 32'h12345678);
        regread(8'h00, rd, rr);
        check("reg0_same", rd, 32'h0);
        regread(8'h08, rd, rr);
        check("reg8_same", rd, 32'h0);
        regread(8'h0C, rd, rr);
        check("regC_same", rd, 32'h0);

        // Partial strobes.
        regwrite(8'h08, 32'h11223344, 4'hF);
        regwrite(8'h08, 32'hAABBCCDD, 4'b0011);
        check("model_strb", mreg[2], 32'h1122CCDD);
        regread(8'h08, rd, rr);
        check("reg8_strb", rd, 32'h1122CCDD);

        // Back-pressure on B blocks the next write.
        bready = 1'b0;
        write_present(8'h00, 32'h0BADF00D, 4'hF);
        write_accept(lat);
        write_present(8'h0C, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bvalid_hold", {31'b0, bvalid}, 32'h1);
            check("aw_blocked", {31'b0, awready}, 32'h0);
        end
        bready = 1'b1;
        write_accept(lat);
        wait_b();
        regread(8'h0C, rd, rr);
        check("regC_after_stall", rd, 32'hCAFEF00D);

        // Out-of-range accesses.
        regread(8'h10, rd, rr);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", {30'b0, rr}, {30'b0, OOR});
        regwrite(8'h10, 32'hFFFFFFFF, 4'hF);
        exp4[0] = 32'h0BADF00D;
        exp4[1] = 32'h12345678;
        exp4[2] = 32'h1122CCDD;
        exp4[3] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            regread(8'(4 * i), rd, rr);
            check("oor_wr_intact", rd, exp4[i]);
        end

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            a = {($urandom_range(0, 3) == 0)
                     ? 4'($urandom_range(1, 15)) : 4'h0,
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3))};
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                regwrite(a, d, 4'($urandom_range(0, 15)));
            else
                regread(a, rd, rr);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset while a write response is pending.
        bready = 1'b0;
        write_present(8'h04, 32'hDEADBEEF, 4'hF);
        write_accept(lat);
        check("pre_rst_bvalid", {31'b0, bvalid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_bvalid_now", {31'b0, bvalid}, 32'h0);
        bq.delete();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        bready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            regread(8'(4 * i), rd, rr);
            check("post_rst_reg", rd, 32'h0);
        end

        repeat (2) @(posedge clk);
        #1;
        if (bq.size() != 0 || rdq.size() != 0) fail("queues_left");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
